// File: rtl/align_shift2048_if.sv
// Word-stream handshake bundle for align_shift2048: an upstream input stream and a
// downstream output stream, each with its own valid/ready pair.
interface align_shift2048_if #(
   parameter int DW = 32
);
   logic          iValid;
   logic [DW-1:0] iData;
   logic          oReady;
   logic          oValid;
   logic [DW-1:0] oData;
   logic          iReady;

   modport master (output iValid, iData, iReady, input oReady, oValid, oData);
   modport slave  (input iValid, iData, iReady, output oReady, oValid, oData);
endinterface

// File: rtl/align_shift2048.sv
// Streaming 2048-bit left shifter (64 x 32-bit words, LSW first) that MSB-aligns the divisor.
// Define LENGTH_CHECK_EN to treat a negative length difference as zero shift and flag oError.
module align_shift2048 #(
   parameter int WORDS = 64,
   parameter int DW    = 32
) (
   input  logic                iClk,
   input  logic                iRstn,
   input  logic                iStart,
   input  logic [11:0]         iLength,
   align_shift2048_if.slave    bus,
   output logic                oBusy,
   output logic                oFinish,
   output logic                oError
);

   typedef enum logic [2:0] {IDLE, ZERO, SHIFT, DISCARD, DONE} state_t;

   localparam logic [6:0] LAST = 7'(WORDS - 1);

   state_t        state, stateNext;
   logic [5:0]    ws;
   logic [4:0]    bs;
   logic [DW-1:0] carry;
   logic [6:0]    k;
   logic [5:0]    dropCnt;
   logic          validQ;
   logic [DW-1:0] dataQ;
   logic [10:0]   lenEff;
   logic          canLoad, readyInt, startAcc, loadZero, loadShift, dropWord, finish;
   logic [DW-1:0] shiftWord, carryNext;

`ifdef LENGTH_CHECK_EN
   assign lenEff = iLength[11] ? 11'd0 : iLength[10:0];

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) oError <= 1'b0;
      else        oError <= startAcc && iLength[11];
   end
`else
   logic unusedLenMsb;
   assign unusedLenMsb = iLength[11];
   assign lenEff       = iLength[10:0];
   assign oError       = 1'b0;
`endif

   assign canLoad    = !validQ || bus.iReady;
   assign shiftWord  = (bus.iData << bs) | carry;
   // A zero bit shift has no spill-over into the next word.
   assign carryNext  = (bs == 5'd0) ? '0 : (bus.iData >> (6'd32 - {1'b0, bs}));
   assign bus.oReady = readyInt;
   assign bus.oValid = validQ;
   assign bus.oData  = dataQ;

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      readyInt  = 1'b0;
      startAcc  = 1'b0;
      loadZero  = 1'b0;
      loadShift = 1'b0;
      dropWord  = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (iStart) begin
               startAcc  = 1'b1;
               stateNext = (lenEff[10:5] != 6'd0) ? ZERO : SHIFT;
            end
         end
         ZERO: begin
            if (canLoad) begin
               loadZero = 1'b1;
               if (k == {1'b0, ws - 6'd1}) stateNext = SHIFT;
            end
         end
         SHIFT: begin
            readyInt = canLoad;
            if (bus.iValid && canLoad) begin
               loadShift = 1'b1;
               if (k == LAST) stateNext = (ws != 6'd0) ? DISCARD : DONE;
            end
         end
         // The top ws input words would land above bit 2047; swallow them.
         DISCARD: begin
            readyInt = 1'b1;
            if (bus.iValid) begin
               dropWord = 1'b1;
               if (dropCnt == ws - 6'd1) stateNext = DONE;
            end
         end
         DONE: begin
            if (canLoad) begin
               finish    = 1'b1;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         ws      <= '0;
         bs      <= '0;
         carry   <= '0;
         k       <= '0;
         dropCnt <= '0;
         validQ  <= 1'b0;
         dataQ   <= '0;
         oBusy   <= 1'b0;
         oFinish <= 1'b0;
      end else begin
         oFinish <= finish;
         if (startAcc) begin
            ws      <= lenEff[10:5];
            bs      <= lenEff[4:0];
            carry   <= '0;
            k       <= '0;
            dropCnt <= '0;
            oBusy   <= 1'b1;
         end else if (finish) begin
            oBusy <= 1'b0;
         end
         if (loadZero) begin
            dataQ  <= '0;
            validQ <= 1'b1;
            k      <= k + 7'd1;
         end else if (loadShift) begin
            dataQ  <= shiftWord;
            carry  <= carryNext;
            validQ <= 1'b1;
            k      <= k + 7'd1;
         end else if (validQ && bus.iReady) begin
            validQ <= 1'b0;
         end
         if (dropWord) dropCnt <= dropCnt + 6'd1;
      end
   end

endmodule

// File: tb/tb_align_shift2048.sv
// Scoreboard bench for align_shift2048: expected words come from a 2048-bit shift model.
module tb_align_shift2048;

   logic        iClk = 1'b0;
   logic        iRstn = 1'b0;
   logic        iStart = 1'b0;
   logic [11:0] iLength = 12'd0;
   logic        oBusy, oFinish, oError;

   align_shift2048_if bus ();

   align_shift2048 dut (
      .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iLength(iLength),
      .bus(bus), .oBusy(oBusy), .oFinish(oFinish), .oError(oError)
   );

   always #5 iClk = ~iClk;

   int          checks = 0;
   int          errors = 0;
   int          outCount = 0;
   logic [31:0] expQ[$];
   logic [31:0] inWords[64];
   logic        stallPrev = 1'b0;
   logic [31:0] stallData = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: the whole operand as one 2048-bit number shifted left, overflow dropped.
   task automatic pushExpected(input logic [10:0] len);
      logic [2047:0] big;
      for (int j = 0; j < 64; j++) big[j*32 +: 32] = inWords[j];
      big = big << len;
      for (int j = 0; j < 64; j++) expQ.push_back(big[j*32 +: 32]);
   endtask

   // Output monitor: pops the scoreboard on every downstream handshake.
   always @(negedge iClk) begin
      if (!iRstn) begin
         stallPrev = 1'b0;
      end else begin
         if (stallPrev) begin
            check("stallValid", 32'(bus.oValid), 32'd1);
            check("stallData", bus.oData, stallData);
         end
         if (bus.oValid && bus.iReady) begin
            if (expQ.size() == 0) check("unexpectedWord", 32'd1, 32'd0);
            else check($sformatf("outWord%0d", 64 - expQ.size()), bus.oData, expQ.pop_front());
            outCount++;
         end
         stallPrev = bus.oValid && !bus.iReady;
         stallData = bus.oData;
      end
   end

   task automatic checkResetOutputs(input string tag);
      check({tag, "_oValid"}, 32'(bus.oValid), 32'd0);
      check({tag, "_oData"}, bus.oData, 32'd0);
      check({tag, "_oReady"}, 32'(bus.oReady), 32'd0);
      check({tag, "_oBusy"}, 32'(oBusy), 32'd0);
      check({tag, "_oFinish"}, 32'(oFinish), 32'd0);
      check({tag, "_oError"}, 32'(oError), 32'd0);
   endtask

   // validMode 0: always valid, 1: random. readyMode 0: always, 1: toggle, 2: random.
   task automatic runOp(input logic [11:0] len, input int validMode, input int readyMode,
                        input bit spurious, input int abortAt);
      int          idx = 0;
      int          cyc = 0;
      int          firstAcc = -1;
      int          finCyc = -1;
      int          errPulses = 0;
      int          startCount = outCount;
      bit          done = 1'b0;
      bit          aborted = 1'b0;
      bit          expErr;
      logic [10:0] effLen;
`ifdef LENGTH_CHECK_EN
      expErr = len[11];
      effLen = len[11] ? 11'd0 : len[10:0];
`else
      expErr = 1'b0;
      effLen = len[10:0];
`endif
      pushExpected(effLen);
      while (!done && !aborted && cyc < 2000) begin
         @(posedge iClk);
         #1;
         if (abortAt > 0 && outCount - startCount >= abortAt) begin
            iRstn = 1'b0;
            #1;
            checkResetOutputs("midReset");
            expQ.delete();
            aborted = 1'b1;
            iStart = 1'b0;
            bus.iValid = 1'b0;
            bus.iReady = 1'b1;
            @(negedge iClk);
            @(posedge iClk);
            #1;
            iRstn = 1'b1;
         end else begin
            iStart     = (cyc == 0) || (spurious && idx < 64 && ($urandom % 4 == 0));
            iLength    = (cyc == 0) ? len : 12'($urandom);
            bus.iValid = (idx < 64) && (validMode == 0 || ($urandom % 3 != 0));
            bus.iData  = inWords[(idx < 64) ? idx : 63];
            bus.iReady = (readyMode == 0) ? 1'b1 :
                         (readyMode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
            @(negedge iClk);
            if (cyc == 1) check("busyAfterStart", 32'(oBusy), 32'd1);
            if (bus.iValid && bus.oReady) begin
               if (firstAcc < 0) firstAcc = cyc;
               idx++;
            end
            if (oError) errPulses++;
            if (oFinish) begin
               done   = 1'b1;
               finCyc = cyc;
               check("busyAtFinish", 32'(oBusy), 32'd0);
            end
            cyc++;
         end
      end
      iStart     = 1'b0;
      bus.iValid = 1'b0;
      bus.iReady = 1'b1;
      if (!aborted) begin
         if (!done) check("finishTimeout", 32'd0, 32'd1);
         check("inputsConsumed", 32'(idx), 32'd64);
         check("outputsProduced", 32'(outCount - startCount), 32'd64);
         check("scoreboardEmpty", 32'(expQ.size()), 32'd0);
         check("errorPulses", 32'(errPulses), 32'(expErr));
         if (validMode == 0 && readyMode == 0 && effLen == 11'd0)
            check("finishLatency", 32'(finCyc - firstAcc), 32'd65);
      end
   endtask

   task automatic fillRandom();
      for (int j = 0; j < 64; j++) inWords[j] = $urandom;
   endtask

   initial begin
      bus.iValid = 1'b0;
      bus.iData  = 32'd0;
      bus.iReady = 1'b1;
      #2;
      checkResetOutputs("reset");
      repeat (2) @(posedge iClk);
      #1;
      iRstn = 1'b1;

      for (int j = 0; j < 64; j++) inWords[j] = 32'h1000_0000 + 32'(j);
      runOp(12'd0, 0, 0, 1'b0, 0);

      for (int j = 0; j < 64; j++) inWords[j] = 32'hFFFF_FFFF;
      runOp(12'd33, 0, 0, 1'b0, 0);

      for (int j = 0; j < 64; j++) inWords[j] = 32'd0;
      inWords[0] = 32'h0000_0001;
      runOp(12'd2047, 0, 0, 1'b0, 0);

      fillRandom();
      runOp(12'd5, 1, 1, 1'b0, 0);

      for (int t = 0; t < 5; t++) begin
         fillRandom();
         runOp(12'($urandom_range(0, 2047)), 1, 2, 1'b1, 0);
      end

      fillRandom();
      runOp(12'd32, 1, 2, 1'b0, 0);

      fillRandom();
      runOp(12'd0, 0, 0, 1'b0, 20);
      for (int j = 0; j < 64; j++) inWords[j] = 32'h1000_0000 + 32'(j);
      runOp(12'd0, 0, 0, 1'b0, 0);

      fillRandom();
      runOp(12'hFFE, 0, 0, 1'b0, 0);

      repeat (2) @(posedge iClk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
